// File: rtl/amp_out_frame_averager.sv
// Frame stats (mean/min/max/clip) over 2^LOG2_N signed samples; result registered on the last accept, visible next cycle.
// Backpressure: non-last samples always accepted; only the last sample of a frame stalls while a result is still pending.
module amp_out_frame_averager #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_mean,
    output logic signed [DATA_W-1:0] m_min,
    output logic signed [DATA_W-1:0] m_max,
    output logic                     m_clip
);

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;

    typedef struct packed {
        logic signed [DATA_W-1:0] mean;
        logic signed [DATA_W-1:0] min;
        logic signed [DATA_W-1:0] max;
        logic                     clip;
    } res_t;

    logic        [CNT_W-1:0]  cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] min_q;
    logic signed [DATA_W-1:0] max_q;
    logic                     clip_q;
    res_t                     res_q;

    logic                     first;
    logic                     last;
    logic                     accept;
    logic                     is_fs;
    logic signed [ACC_W-1:0]  samp_ext;
    logic signed [ACC_W-1:0]  nxt_acc;
    logic signed [DATA_W-1:0] nxt_min;
    logic signed [DATA_W-1:0] nxt_max;
    logic                     nxt_clip;

    assign first    = (cnt == '0);
    assign last     = (cnt == CNT_W'(N - 1));
    assign s_ready  = rst_n & ~clear & ~(last & m_valid & ~m_ready);
    assign accept   = s_valid & s_ready;

    assign is_fs    = (s_data == {1'b0, {(DATA_W-1){1'b1}}}) ||
                      (s_data == {1'b1, {(DATA_W-1){1'b0}}});
    assign samp_ext = ACC_W'(s_data);

    // Frame-so-far values including the current sample; a fresh frame ignores stale state.
    assign nxt_acc  = (first ? '0 : acc) + samp_ext;
    assign nxt_min  = (first || s_data < min_q) ? s_data : min_q;
    assign nxt_max  = (first || s_data > max_q) ? s_data : max_q;
    assign nxt_clip = (first ? 1'b0 : clip_q) | is_fs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            min_q  <= '0;
            max_q  <= '0;
            clip_q <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            acc    <= '0;
            min_q  <= '0;
            max_q  <= '0;
            clip_q <= 1'b0;
        end else if (accept) begin
            cnt    <= last ? '0 : cnt + CNT_W'(1);
            acc    <= nxt_acc;
            min_q  <= nxt_min;
            max_q  <= nxt_max;
            clip_q <= nxt_clip;
        end
    end

    // Mean is the top DATA_W bits of the sum, i.e. an arithmetic shift right by LOG2_N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            res_q   <= '0;
        end else if (accept && last) begin
            m_valid    <= 1'b1;
            res_q.mean <= nxt_acc[ACC_W-1:LOG2_N];
            res_q.min  <= nxt_min;
            res_q.max  <= nxt_max;
            res_q.clip <= nxt_clip;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign m_mean = res_q.mean;
    assign m_min  = res_q.min;
    assign m_max  = res_q.max;
    assign m_clip = res_q.clip;

endmodule

// File: tb/tb_amp_out_frame_averager.sv
// Directed bench for amp_out_frame_averager (DATA_W=16, LOG2_N=2).
module tb_amp_out_frame_averager;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] m_mean;
    logic signed [15:0] m_min;
    logic signed [15:0] m_max;
    logic               m_clip;

    int checks = 0;
    int errors = 0;

    amp_out_frame_averager #(.DATA_W(16), .LOG2_N(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_mean (m_mean),
        .m_min  (m_min),
        .m_max  (m_max),
        .m_clip (m_clip)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s0, s1, s2, s3;
        int mean, mn, mx, clip;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input int mean, input int mn, input int mx, input int clip);
        chk({nm, "_valid"}, int'(m_valid), 1);
        chk({nm, "_mean"}, int'(m_mean), mean);
        chk({nm, "_min"}, int'(m_min), mn);
        chk({nm, "_max"}, int'(m_max), mx);
        chk({nm, "_clip"}, int'(m_clip), clip);
    endtask

    // Present one sample, wait (bounded) until it is accepted; returns at posedge+1.
    task automatic send(input int v);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'(v);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout sample %0d s_ready stayed 0", v);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic setv(input int i, input int a, input int b, input int c, input int d,
                        input int mean, input int mn, input int mx, input int clip);
        vt[i].s0 = a; vt[i].s1 = b; vt[i].s2 = c; vt[i].s3 = d;
        vt[i].mean = mean; vt[i].mn = mn; vt[i].mx = mx; vt[i].clip = clip;
    endtask

    initial begin
        setv(0,    100,  200,  300,    400,    250,    100,   400, 0);
        setv(1,     -1,   -2,   -2,     -2,     -2,     -2,    -1, 0);
        setv(2,  32767,32767,32767,  32767,  32767,  32767, 32767, 1);
        setv(3,      0,    0,    0, -32768,  -8192, -32768,     0, 1);
        setv(4,     -5,    3,    7,     -1,      1,     -5,     7, 0);
        setv(5,     -3,    0,    0,      0,     -1,     -3,     0, 0);

        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_mean", int'(m_mean), 0);
        chk("rst_minmax", int'(m_min) | int'(m_max), 0);
        chk("rst_clip", int'(m_clip), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_s_ready", int'(s_ready), 1);

        // Table: back-to-back frames, result visible exactly one cycle.
        for (int i = 0; i < 6; i++) begin
            send(vt[i].s0);
            send(vt[i].s1);
            send(vt[i].s2);
            chk("no_early_valid", int'(m_valid), 0);
            send(vt[i].s3);
            @(negedge clk);
            chk_res($sformatf("vec%0d", i), vt[i].mean, vt[i].mn, vt[i].mx, vt[i].clip);
            @(negedge clk);
            chk($sformatf("vec%0d_valid_drop", i), int'(m_valid), 0);
            @(posedge clk); #1;
        end

        // Backpressure: second frame's last sample stalls until the first result is taken.
        m_ready = 1'b0;
        for (int v = 1; v <= 7; v++) send(v);
        s_valid = 1'b1;
        s_data  = 16'sd8;
        repeat (3) begin
            @(negedge clk);
            chk("bp_s_ready_low", int'(s_ready), 0);
            chk_res("bp_hold", 2, 1, 4, 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_s_ready_high", int'(s_ready), 1);
        chk_res("bp_first", 2, 1, 4, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk_res("bp_second", 6, 5, 8, 0);
        @(negedge clk);
        chk("bp_valid_drop", int'(m_valid), 0);
        @(posedge clk); #1;

        // Clear aborts a partial frame and refuses the sample presented alongside it.
        send(1000);
        send(2000);
        clear = 1'b1; s_valid = 1'b1; s_data = 16'sd9999;
        @(negedge clk);
        chk("clear_s_ready", int'(s_ready), 0);
        @(posedge clk); #1;
        clear = 1'b0; s_valid = 1'b0;
        send(10); send(20); send(30);
        chk("clear_no_early", int'(m_valid), 0);
        send(40);
        @(negedge clk);
        chk_res("clear_frame", 25, 10, 40, 0);
        @(posedge clk); #1;

        // Reset mid-frame with a result pending.
        m_ready = 1'b0;
        send(4); send(8); send(12); send(16);
        send(1); send(2); send(3);
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", int'(m_valid), 0);
        chk("arst_s_ready", int'(s_ready), 0);
        chk("arst_mean", int'(m_mean), 0);
        chk("arst_minmax", int'(m_min) | int'(m_max), 0);
        chk("arst_clip", int'(m_clip), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        send(4); send(4); send(4);
        chk("arst_no_early", int'(m_valid), 0);
        send(4);
        @(negedge clk);
        chk_res("arst_frame", 4, 4, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amp_out_frame_averager.md
# amp_out_frame_averager

Digital stage directly downstream of the op-amp output sampling ADC. It accepts signed ADC samples of the amplifier output over a valid/ready stream, groups them into frames of 2^LOG2_N samples, and emits one result per frame: the frame mean, minimum, maximum and a clip flag. Results feed the AC-response readout logic, which may apply backpressure.

## Interface
- DATA_W, 16: sample width, signed two's complement.
- LOG2_N, 2: frame length N = 2^LOG2_N; legal range 0..8.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort of the partial frame.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DATA_W  signed ADC sample.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts result.
- m_mean  out  DATA_W  signed frame mean.
- m_min  out  DATA_W  signed frame minimum.
- m_max  out  DATA_W  signed frame maximum.
- m_clip  out  1  some frame sample equalled the positive or negative full-scale code.

## Operation
- Accept = s_valid & s_ready. Result taken = m_valid & m_ready.
- Frame state: sample counter cnt (0..N-1), accumulator acc (signed, DATA_W+LOG2_N bits, no overflow possible), running min, max, clip.
- On accept with cnt==0: min=max=sample, clip=(sample==full-scale max or min code), acc=sample.
- On accept with cnt>0: acc+=sample; min/max update by signed compare; clip ORs in.
- On accept with cnt==N-1 (last sample): output registers load mean=(acc+sample)>>>LOG2_N (arithmetic shift, rounds toward -inf), and min/max/clip including this sample; m_valid<=1; cnt<=0. With LOG2_N=0 every sample is a last sample and mean=sample.
- Otherwise accept increments cnt.
- Output register: one entry. While m_valid & !m_ready, all m_* hold stable. Taken without a new load -> m_valid<=0; m_* data keep last value.
- s_ready = rst_n & !clear & !(cnt==N-1 & m_valid & !m_ready). Non-last samples are accepted even while a result is pending; only the last sample of a frame stalls.
- Last sample accepted in the same cycle the pending result is taken: new result loads, m_valid stays 1 (no bubble).
- clear: cnt, acc, min, max, clip zeroed; any sample presented that cycle is not accepted (s_ready=0). Pending output result is unaffected and still delivered.
- Reset: cnt=0, acc=0, m_valid=0, m_mean=m_min=m_max=0, m_clip=0; s_ready=0 while rst_n low, 1 on the first cycle after release (clear low).

## Timing
- Latency: m_valid rises on the clock edge that accepts the Nth sample; visible in the following cycle.
- Throughput: one sample per clock sustained when m_ready held high; one result every N cycles.
- s_ready is combinational from clear, m_ready and internal state; no combinational path from s_valid or s_data to any output.
- Reset mid-frame discards the partial frame and any pending result.

## Test plan
- DATA_W=16, LOG2_N=2; samples 100,200,300,400 back-to-back, m_ready=1 -> one result cycle after 4th accept: mean 250, min 100, max 400, clip 0; m_valid high exactly one cycle.
- Samples -1,-2,-2,-2 -> sum -7, mean -2 (floor), min -2, max -1, clip 0.
- Four samples of 32767 -> mean 32767, clip 1; then 0,0,0,-32768 -> mean -8192, min -32768, max 0, clip 1.
- m_ready=0, 8 samples (1..8) continuously -> first result (mean 2, min 1, max 4) held stable; s_ready drops while sample 8 is presented; raise m_ready -> first result taken, sample 8 accepted same cycle, second result mean 6, min 5, max 8, no bubble.
- Samples 1000,2000, then clear with s_valid high and s_data 9999 (not accepted), then 10,20,30,40 -> only result mean 25, min 10, max 40.
- Assert rst_n low after 3 samples of a frame with a result pending -> all outputs 0, m_valid 0; after release, 4,4,4,4 -> mean 4.
